// File: rtl/ahb_burst_master.sv
// AHB-lite burst master: turns command/data requests into NONSEQ/SEQ/BUSY bursts with a write-data FIFO.
// Define AHB_BURST_1KB_CHECK_EN to reject INCR-family bursts that would cross a 1 KB boundary.
module ahb_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_addr,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_size,
    input  logic [2:0]            cmd_burst,
    input  logic [4:0]            cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_err,
    output logic                  rdata_last,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic [1:0]            PSIZE,
    output logic [1:0]            PTRANS,
    output logic [2:0]            PBURST,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PRESP,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DRAIN, S_ABORT, S_DONE} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic push, pop, fifo_full, fifo_empty;

    logic        cmd_fire, cmd_reject, misaligned, crosses_1kb;
    logic [4:0]  cmd_beats;
    logic [4:0]  beats_total, beat_cnt;
    logic        dp_active, dp_write, dp_last, err_flag;
    logic        addr_accept, last_beat;
    logic [31:0] addr_inc, wrap_mask, next_addr;

    assign fifo_full   = (count == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign push        = wdata_valid && wdata_ready;
    assign addr_accept = (state == S_ADDR) && PREADY && PTRANS[1];
    assign pop         = addr_accept && PWRITE;
    assign count_next  = count + CW'(push) - CW'(pop);
    assign last_beat   = (beat_cnt == beats_total - 5'd1);

    always_comb begin
        cmd_ready   = (state == S_IDLE) && !HRESET && (!cmd_write || !fifo_empty);
        wdata_ready = !fifo_full && !HRESET;
        done        = (state == S_DONE);
        err         = (state == S_DONE) && err_flag;
    end

    always_comb begin
        cmd_fire = cmd_valid && cmd_ready;
        case (cmd_burst)
            3'd0:       cmd_beats = 5'd1;
            3'd1:       cmd_beats = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
            3'd2, 3'd3: cmd_beats = 5'd4;
            3'd4, 3'd5: cmd_beats = 5'd8;
            default:    cmd_beats = 5'd16;
        endcase
        misaligned = (cmd_size == 2'd3) ||
                     (cmd_size == 2'd1 && cmd_addr[0]) ||
                     (cmd_size == 2'd2 && cmd_addr[1:0] != 2'b00);
`ifdef AHB_BURST_1KB_CHECK_EN
        begin
            logic [31:0] last_addr;
            last_addr   = cmd_addr + ((32'(cmd_beats) - 32'd1) << cmd_size);
            crosses_1kb = (cmd_burst == 3'd0 || cmd_burst[0]) &&
                          (last_addr[31:10] != cmd_addr[31:10]);
        end
`else
        crosses_1kb = 1'b0;
`endif
        cmd_reject = misaligned || crosses_1kb;
    end

    // WRAP bursts keep the upper address bits and wrap the low bits within beats*size bytes
    always_comb begin
        addr_inc  = 32'd1 << PSIZE;
        wrap_mask = (32'(beats_total) << PSIZE) - 32'd1;
        if (PBURST != 3'd0 && !PBURST[0])
            next_addr = (PADDR & ~wrap_mask) | ((PADDR + addr_inc) & wrap_mask);
        else
            next_addr = PADDR + addr_inc;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_next = cmd_reject ? S_DONE : S_ADDR;
            S_ADDR: begin
                if (PREADY) begin
                    if (dp_active && PRESP)
                        state_next = S_ABORT;
                    else if (addr_accept && last_beat)
                        state_next = S_DRAIN;
                end
            end
            S_DRAIN: if (PREADY) state_next = PRESP ? S_ABORT : S_DONE;
            S_ABORT: if (!dp_active || PREADY) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PSIZE       <= 2'd2;
            PTRANS      <= T_IDLE;
            PBURST      <= 3'd0;
            PWDATA      <= '0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rdata_err   <= 1'b0;
            rdata_last  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            beats_total <= 5'd1;
            beat_cnt    <= '0;
            dp_active   <= 1'b0;
            dp_write    <= 1'b0;
            dp_last     <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            count       <= count_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                PWDATA <= mem[rd_ptr];
            end
            if (cmd_fire) begin
                err_flag    <= cmd_reject;
                beats_total <= cmd_beats;
                beat_cnt    <= '0;
                dp_active   <= 1'b0;
                if (!cmd_reject) begin
                    PADDR  <= cmd_addr;
                    PWRITE <= cmd_write;
                    PSIZE  <= cmd_size;
                    PBURST <= cmd_burst;
                    PTRANS <= T_NONSEQ;
                end
            end
            // Everything on the bus advances only when the slave is ready
            if (PREADY && (state == S_ADDR || state == S_DRAIN || state == S_ABORT)) begin
                if (dp_active && !dp_write && state != S_ABORT) begin
                    rdata_valid <= 1'b1;
                    rdata       <= PRDATA;
                    rdata_err   <= PRESP;
                    rdata_last  <= dp_last;
                end
                dp_active <= addr_accept;
                dp_write  <= PWRITE;
                dp_last   <= last_beat;
                if (dp_active && PRESP && state != S_ABORT) begin
                    PTRANS   <= T_IDLE;
                    err_flag <= 1'b1;
                end else if (addr_accept) begin
                    beat_cnt <= beat_cnt + 5'd1;
                    if (last_beat) begin
                        PTRANS <= T_IDLE;
                    end else begin
                        PADDR  <= next_addr;
                        PTRANS <= (PWRITE && count_next == '0) ? T_BUSY : T_SEQ;
                    end
                end else if (state == S_ADDR && PTRANS == T_BUSY && count_next != '0) begin
                    PTRANS <= T_SEQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: per-cycle bus trace compared against hand-computed bursts.
module tb_ahb_burst_master;

    localparam int DW   = 32;
    localparam int MAXC = 64;
    localparam logic [31:0] RBASE = 32'hCAFE_0000;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [31:0]   cmd_addr;
    logic [1:0]    cmd_size;
    logic [2:0]    cmd_burst;
    logic [4:0]    cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_err, rdata_last, done, err;
    logic [DW-1:0] rdata;
    logic [31:0]   PADDR;
    logic          PWRITE;
    logic [1:0]    PSIZE, PTRANS;
    logic [2:0]    PBURST;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PRESP;

    ahb_burst_master #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_err(rdata_err), .rdata_last(rdata_last),
        .done(done), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSIZE(PSIZE), .PTRANS(PTRANS), .PBURST(PBURST),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRESP(PRESP), .PRDATA(PRDATA)
    );

    always #5 HCLK = ~HCLK;

    int tests_run, tests_failed;
    logic [31:0] tr [MAXC];
    logic [31:0] ad [MAXC];
    logic [31:0] wd [MAXC];
    logic [31:0] ctl [MAXC];
    logic [31:0] rv [MAXC];
    logic [31:0] rd [MAXC];
    logic [31:0] re [MAXC];
    logic [31:0] rl [MAXC];
    logic [31:0] dn [MAXC];
    logic [31:0] er [MAXC];
    logic [31:0] cr [MAXC];
    logic [31:0] wr_rdy [MAXC];
    int done_cycle, rv_count;
    int stall_cycle, err_cycle, push_start, push_n, rst_start;
    logic [31:0] push_base;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic clearKnobs();
        stall_cycle = -1;
        err_cycle   = -1;
        push_start  = 1000;
        push_n      = 0;
        push_base   = 32'h0;
        rst_start   = 0;
    endtask

    task automatic pushWords(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wdata_valid = 1'b1;
            wdata       = base + 32'(i);
            @(posedge HCLK); #1;
        end
        wdata_valid = 1'b0;
    endtask

    // Issues one command, then records the bus cycle by cycle (cycle 1 = first cycle after acceptance)
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                                 input logic [2:0] burst, input logic [4:0] len, input int budget);
        int waited;
        int pushed;
        for (int i = 0; i < MAXC; i++) begin
            tr[i] = '0; ad[i] = '0; wd[i] = '0; ctl[i] = '0; rv[i] = '0; rd[i] = '0;
            re[i] = '0; rl[i] = '0; dn[i] = '0; er[i] = '0; cr[i] = '0; wr_rdy[i] = '0;
        end
        done_cycle = -1;
        rv_count   = 0;
        pushed     = 0;
        cmd_addr = addr; cmd_write = wr; cmd_size = size; cmd_burst = burst; cmd_len = len;
        cmd_valid = 1'b1;
        #1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(posedge HCLK); #1;
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= budget && c < MAXC; c++) begin
            PREADY = (c != stall_cycle);
            PRESP  = (c == err_cycle);
            PRDATA = RBASE + 32'(c);
            HRESET = (rst_start > 0 && c >= rst_start && c < rst_start + 2);
            if (c >= push_start && c < push_start + push_n) begin
                wdata_valid = 1'b1;
                wdata       = push_base + 32'(pushed);
                pushed++;
            end else begin
                wdata_valid = 1'b0;
            end
            #1;
            tr[c] = 32'(PTRANS);  ad[c] = PADDR;  wd[c] = PWDATA;
            ctl[c] = 32'({PWRITE, PSIZE, PBURST});
            rv[c] = 32'(rdata_valid); rd[c] = rdata; re[c] = 32'(rdata_err); rl[c] = 32'(rdata_last);
            dn[c] = 32'(done); er[c] = 32'(err); cr[c] = 32'(cmd_ready); wr_rdy[c] = 32'(wdata_ready);
            if (rdata_valid) rv_count++;
            if (done && done_cycle < 0) done_cycle = c;
            if (done_cycle >= 0 && c == done_cycle + 1) break;
            @(posedge HCLK); #1;
        end
        PREADY = 1'b1; PRESP = 1'b0; wdata_valid = 1'b0; HRESET = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_b [4];
        logic [31:0] exp_ct [12];
        logic [31:0] exp_ca [11];
        tests_run = 0; tests_failed = 0;
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
        cmd_burst = '0; cmd_len = '0; wdata_valid = 1'b0; wdata = '0;
        PREADY = 1'b1; PRESP = 1'b0; PRDATA = '0;
        clearKnobs();

        repeat (3) @(posedge HCLK); #1;
        checkOutput("rst_ptrans", 32'(PTRANS), 32'd0);
        checkOutput("rst_paddr", PADDR, 32'd0);
        checkOutput("rst_ctl", 32'({PWRITE, PSIZE, PBURST}), 32'h10);
        checkOutput("rst_pwdata", PWDATA, 32'd0);
        checkOutput("rst_rdata", 32'({rdata_valid, rdata_last, rdata_err}), 32'd0);
        checkOutput("rst_rdata_word", rdata, 32'd0);
        checkOutput("rst_done_err", 32'({done, err}), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        HRESET = 1'b0; #1;
        checkOutput("idle_wdata_ready", 32'(wdata_ready), 32'd1);
        checkOutput("idle_cmd_ready_read", 32'(cmd_ready), 32'd1);

        // WORD INCR4 write with all data pre-pushed
        pushWords(4, 32'hA000_0000);
        applyStimulus(32'h2000_0000, 1'b1, 2'd2, 3'd3, 5'd0, 12);
        for (int k = 0; k < 4; k++) begin
            checkOutput("A_trans", tr[k+1], (k == 0) ? 32'd2 : 32'd3);
            checkOutput("A_addr", ad[k+1], 32'h2000_0000 + 32'(4*k));
            checkOutput("A_pwdata", wd[k+2], 32'hA000_0000 + 32'(k));
        end
        checkOutput("A_ctl", ctl[3], 32'h33);
        checkOutput("A_idle", tr[5], 32'd0);
        checkOutput("A_done_cycle", done_cycle, 32'd6);
        checkOutput("A_err", er[6], 32'd0);

        // BYTE WRAP4 read from offset 2
        exp_b = '{32'h2000_0002, 32'h2000_0003, 32'h2000_0000, 32'h2000_0001};
        applyStimulus(32'h2000_0002, 1'b0, 2'd0, 3'd2, 5'd0, 12);
        checkOutput("B_ctl", ctl[1], 32'h02);
        for (int k = 0; k < 4; k++) begin
            checkOutput("B_addr", ad[k+1], exp_b[k]);
            checkOutput("B_rvalid", rv[k+3], 32'd1);
            checkOutput("B_rdata", rd[k+3], RBASE + 32'(k + 2));
            checkOutput("B_rlast", rl[k+3], 32'(k == 3));
        end
        checkOutput("B_rv_count", rv_count, 32'd4);
        checkOutput("B_done_cycle", done_cycle, 32'd6);
        checkOutput("B_err", er[6], 32'd0);
        checkOutput("B_cmd_ready_busy", cr[6], 32'd0);
        checkOutput("B_cmd_ready_again", cr[7], 32'd1);

        // HALFWORD INCR8 write that runs dry after two beats and refills later
        pushWords(2, 32'hC000_0000);
        push_start = 5; push_n = 6; push_base = 32'hC000_0002;
        exp_ct = '{32'd2, 32'd3, 32'd1, 32'd1, 32'd1, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd0};
        exp_ca = '{32'h2000_0000, 32'h2000_0002, 32'h2000_0004, 32'h2000_0004, 32'h2000_0004,
                   32'h2000_0004, 32'h2000_0006, 32'h2000_0008, 32'h2000_000A, 32'h2000_000C,
                   32'h2000_000E};
        applyStimulus(32'h2000_0000, 1'b1, 2'd1, 3'd5, 5'd0, 20);
        clearKnobs();
        for (int c = 1; c <= 12; c++) checkOutput("C_trans", tr[c], exp_ct[c-1]);
        for (int c = 1; c <= 11; c++) checkOutput("C_addr", ad[c], exp_ca[c-1]);
        checkOutput("C_pwdata_b0", wd[2], 32'hC000_0000);
        checkOutput("C_pwdata_busy", wd[5], 32'hC000_0001);
        for (int k = 2; k < 8; k++) checkOutput("C_pwdata", wd[k+5], 32'hC000_0000 + 32'(k));
        checkOutput("C_done_cycle", done_cycle, 32'd13);
        checkOutput("C_err", er[13], 32'd0);
        checkOutput("C_fifo_drained", cr[14], 32'd0);

        // WORD INCR4 read with an error response on beat 1
        err_cycle = 3;
        applyStimulus(32'h2000_1000, 1'b0, 2'd2, 3'd3, 5'd0, 12);
        clearKnobs();
        checkOutput("D_rv_b0", rv[3], 32'd1);
        checkOutput("D_rerr_b0", re[3], 32'd0);
        checkOutput("D_rv_b1", rv[4], 32'd1);
        checkOutput("D_rerr_b1", re[4], 32'd1);
        checkOutput("D_rdata_b1", rd[4], RBASE + 32'd3);
        checkOutput("D_idle_after_err", tr[4], 32'd0);
        checkOutput("D_b2_dropped", rv[5], 32'd0);
        checkOutput("D_rv_count", rv_count, 32'd2);
        checkOutput("D_done_cycle", done_cycle, 32'd5);
        checkOutput("D_err", er[5], 32'd1);

        // Misaligned WORD command is rejected without bus traffic
        applyStimulus(32'h2000_0002, 1'b0, 2'd2, 3'd0, 5'd0, 6);
        checkOutput("E_done_cycle", done_cycle, 32'd1);
        checkOutput("E_err", er[1], 32'd1);
        checkOutput("E_no_traffic", tr[1] | tr[2], 32'd0);

        // WORD INCR16 from 0x3F0 runs past the 1 KB boundary
        applyStimulus(32'h2000_03F0, 1'b0, 2'd2, 3'd7, 5'd0, 24);
`ifdef AHB_BURST_1KB_CHECK_EN
        checkOutput("F_done_cycle", done_cycle, 32'd1);
        checkOutput("F_err", er[1], 32'd1);
        checkOutput("F_no_traffic", tr[1], 32'd0);
`else
        checkOutput("F_first_trans", tr[1], 32'd2);
        checkOutput("F_last_addr", ad[16], 32'h2000_042C);
        checkOutput("F_done_cycle", done_cycle, 32'd18);
        checkOutput("F_err", er[18], 32'd0);
        checkOutput("F_rv_count", rv_count, 32'd16);
`endif

        // WORD INCR4 read with one wait state on beat 1
        stall_cycle = 3;
        applyStimulus(32'h2000_2000, 1'b0, 2'd2, 3'd3, 5'd0, 12);
        clearKnobs();
        checkOutput("G_addr_held", ad[4], 32'h2000_2008);
        checkOutput("G_trans_held", tr[4], 32'd3);
        checkOutput("G_no_rv_in_stall", rv[4], 32'd0);
        checkOutput("G_rdata_b1", rd[5], RBASE + 32'd4);
        checkOutput("G_rlast", rl[7], 32'd1);
        checkOutput("G_done_cycle", done_cycle, 32'd7);

        // Reset during beat 2 of a WORD INCR8 write
        pushWords(8, 32'hE000_0000);
        rst_start = 3;
        applyStimulus(32'h2000_0100, 1'b1, 2'd2, 3'd5, 5'd0, 12);
        clearKnobs();
        checkOutput("H_beat2_addr", ad[3], 32'h2000_0108);
        checkOutput("H_wdata_ready_rst", wr_rdy[3] | wr_rdy[4], 32'd0);
        checkOutput("H_cmd_ready_rst", cr[3] | cr[4], 32'd0);
        checkOutput("H_trans_idle", tr[4], 32'd0);
        checkOutput("H_addr_cleared", ad[4], 32'd0);
        checkOutput("H_wdata_ready_after", wr_rdy[5], 32'd1);
        checkOutput("H_fifo_flushed", cr[5], 32'd0);
        checkOutput("H_no_done", done_cycle, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
